// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM time-slice arbiter: slot encodings,
// default slot length and the fixed slot rotation order.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    SLOT_CPU   = 2'd0,
    SLOT_VIDEO = 2'd1,
    SLOT_SPI   = 2'd2
  } slot_e;

  localparam int DEFAULT_SLOT_CYCLES = 4;

  // Fixed rotation CPU -> VIDEO -> SPI -> CPU.
  function automatic slot_e next_slot(input slot_e s);
    case (s)
      SLOT_CPU:   return SLOT_VIDEO;
      SLOT_VIDEO: return SLOT_SPI;
      default:    return SLOT_CPU;
    endcase
  endfunction

endpackage

// File: rtl/sram_slot_timer.sv
// Phase counter and slot rotation. slot_start marks phase 0 of a slot,
// slot_end marks its last phase (the coming edge enters the next slot).
module sram_slot_timer
  import sram_arbiter_pkg::*;
#(
  parameter int SLOT_CYCLES = DEFAULT_SLOT_CYCLES,
  localparam int PW = $clog2(SLOT_CYCLES)
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [1:0]    slot_o,
  output logic [PW-1:0] phase_o,
  output logic          slot_start_o,
  output logic          slot_end_o
);

  localparam logic [PW-1:0] LAST_PHASE = PW'(SLOT_CYCLES - 1);

  slot_e         slot_q, slot_d;
  logic [PW-1:0] phase_q, phase_d;

  // Advance the phase every clock; on wrap, hand the SRAM to the next owner.
  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    phase_d = phase_q + 1'b1;
    slot_d  = slot_q;
    if (phase_q == LAST_PHASE) begin
      phase_d = '0;
      slot_d  = next_slot(slot_q);
    end
  end

  // Slot/phase state register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q  <= SLOT_CPU;
      phase_q <= '0;
    end else begin
      slot_q  <= slot_d;
      phase_q <= phase_d;
    end
  end

  assign slot_o       = slot_q;
  assign phase_o      = phase_q;
  assign slot_start_o = (phase_q == '0);
  assign slot_end_o   = (phase_q == LAST_PHASE);

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the CPU, video fetch and SPI bridge
// in fixed round-robin slots. All SRAM strobes and requester outputs are
// registered; the owner of a slot is latched on the edge entering phase 0.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int SLOT_CYCLES = DEFAULT_SLOT_CYCLES,
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_ram_enable,
  input  logic                  cpu_is_readonly,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_done,
  input  logic [ADDR_WIDTH-1:0] video_addr,
  output logic [DATA_WIDTH-1:0] video_rdata,
  output logic                  video_valid,
  input  logic                  spi_req,
  input  logic [ADDR_WIDTH-1:0] spi_addr,
  input  logic                  spi_we,
  input  logic [DATA_WIDTH-1:0] spi_wdata,
  output logic [DATA_WIDTH-1:0] spi_rdata,
  output logic                  spi_ack,
  output logic [1:0]            slot,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_dout,
  input  logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_data_oe,
  output logic                  ram_oe_n,
  output logic                  ram_we_n
);

  localparam int PW = $clog2(SLOT_CYCLES);
  localparam logic [PW-1:0] WE_LAST_PHASE = PW'(SLOT_CYCLES - 2);

  logic [1:0]    slot_w;
  logic [PW-1:0] phase_w;
  logic          slot_start_w, slot_end_w;

  sram_slot_timer #(.SLOT_CYCLES(SLOT_CYCLES)) u_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .slot_o       (slot_w),
    .phase_o      (phase_w),
    .slot_start_o (slot_start_w),
    .slot_end_o   (slot_end_w)
  );

  // Request of the owner of the slot about to begin.
  logic                  sel_pend, sel_rd, sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_dout;

  // Registered state and outputs.
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_dout_q, ram_dout_d;
  logic                  oe_n_q, oe_n_d, we_n_q, we_n_d, data_oe_q, data_oe_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d, video_rdata_q, video_rdata_d;
  logic [DATA_WIDTH-1:0] spi_rdata_q, spi_rdata_d;
  logic                  cpu_done_q, cpu_done_d, video_valid_q, video_valid_d;
  logic                  spi_ack_q, spi_ack_d;

  // Decode what the next owner wants; ROM writes and unmapped CPU cycles become no-ops.
  always_comb begin
    sel_pend = 1'b0;
    sel_rd   = 1'b0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_dout = '0;
    case (next_slot(slot_e'(slot_w)))
      SLOT_CPU: begin
        sel_pend = 1'b1;
        sel_rd   = cpu_ram_enable & ~cpu_we;
        sel_wr   = cpu_ram_enable & cpu_we & ~cpu_is_readonly;
        sel_addr = cpu_addr;
        sel_dout = cpu_wdata;
      end
      SLOT_VIDEO: begin
        sel_pend = 1'b1;
        sel_rd   = 1'b1;
        sel_addr = video_addr;
      end
      SLOT_SPI: begin
        // The bridge may write the ROM image, so readonly is not consulted.
        sel_pend = spi_req;
        sel_rd   = spi_req & ~spi_we;
        sel_wr   = spi_req & spi_we;
        sel_addr = spi_addr;
        sel_dout = spi_wdata;
      end
      default: ;
    endcase
  end

  // Strobe sequencing within a slot, completion of the ending slot and start of the next.
  always_comb begin
    pend_d        = pend_q;
    ram_addr_d    = ram_addr_q;
    ram_dout_d    = ram_dout_q;
    oe_n_d        = oe_n_q;
    data_oe_d     = data_oe_q;
    we_n_d        = we_n_q;
    cpu_rdata_d   = cpu_rdata_q;
    video_rdata_d = video_rdata_q;
    spi_rdata_d   = spi_rdata_q;
    cpu_done_d    = 1'b0;
    video_valid_d = 1'b0;
    spi_ack_d     = 1'b0;

    // Write pulse sits inside the data drive window: phases 1..S-2.
    if (slot_start_w && data_oe_q) we_n_d = 1'b0;
    if (phase_w == WE_LAST_PHASE)  we_n_d = 1'b1;

    if (slot_end_w) begin
      if (pend_q) begin
        case (slot_e'(slot_w))
          SLOT_CPU:   cpu_done_d    = 1'b1;
          SLOT_VIDEO: video_valid_d = 1'b1;
          SLOT_SPI:   spi_ack_d     = 1'b1;
          default: ;
        endcase
      end
      if (!oe_n_q) begin
        case (slot_e'(slot_w))
          SLOT_CPU:   cpu_rdata_d   = ram_din;
          SLOT_VIDEO: video_rdata_d = ram_din;
          SLOT_SPI:   spi_rdata_d   = ram_din;
          default: ;
        endcase
      end
      pend_d    = sel_pend;
      oe_n_d    = ~sel_rd;
      data_oe_d = sel_wr;
      we_n_d    = 1'b1;
      if (sel_rd || sel_wr) ram_addr_d = sel_addr;
      if (sel_wr)           ram_dout_d = sel_dout;
    end
  end

  // Register bank; reset releases every strobe and drops an in-flight access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q        <= 1'b0;
      ram_addr_q    <= '0;
      ram_dout_q    <= '0;
      oe_n_q        <= 1'b1;
      data_oe_q     <= 1'b0;
      we_n_q        <= 1'b1;
      cpu_rdata_q   <= '0;
      video_rdata_q <= '0;
      spi_rdata_q   <= '0;
      cpu_done_q    <= 1'b0;
      video_valid_q <= 1'b0;
      spi_ack_q     <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      ram_addr_q    <= ram_addr_d;
      ram_dout_q    <= ram_dout_d;
      oe_n_q        <= oe_n_d;
      data_oe_q     <= data_oe_d;
      we_n_q        <= we_n_d;
      cpu_rdata_q   <= cpu_rdata_d;
      video_rdata_q <= video_rdata_d;
      spi_rdata_q   <= spi_rdata_d;
      cpu_done_q    <= cpu_done_d;
      video_valid_q <= video_valid_d;
      spi_ack_q     <= spi_ack_d;
    end
  end

  assign slot        = slot_w;
  assign ram_addr    = ram_addr_q;
  assign ram_dout    = ram_dout_q;
  assign ram_oe_n    = oe_n_q;
  assign ram_we_n    = we_n_q;
  assign ram_data_oe = data_oe_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_done    = cpu_done_q;
  assign video_rdata = video_rdata_q;
  assign video_valid = video_valid_q;
  assign spi_rdata   = spi_rdata_q;
  assign spi_ack     = spi_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM modelled as a 128K array, a slot-level
// reference model predicting every output each cycle, directed scenarios
// with literal expectations, then randomized traffic.
module tb_sram_arbiter;

  localparam int S  = 4;
  localparam int AW = 17;
  localparam int DW = 8;
  localparam int MEM_WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] cpu_addr = '0, video_addr = '0, spi_addr = '0;
  logic          cpu_we = 1'b0, cpu_ram_enable = 1'b0, cpu_is_readonly = 1'b0;
  logic [DW-1:0] cpu_wdata = '0, spi_wdata = '0;
  logic          spi_req = 1'b0, spi_we = 1'b0;
  logic [DW-1:0] cpu_rdata, video_rdata, spi_rdata, ram_dout, ram_din;
  logic          cpu_done, video_valid, spi_ack;
  logic [1:0]    slot;
  logic [AW-1:0] ram_addr;
  logic          ram_data_oe, ram_oe_n, ram_we_n;

  sram_arbiter #(.SLOT_CYCLES(S), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_ram_enable(cpu_ram_enable), .cpu_is_readonly(cpu_is_readonly),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .video_addr(video_addr), .video_rdata(video_rdata), .video_valid(video_valid),
    .spi_req(spi_req), .spi_addr(spi_addr), .spi_we(spi_we), .spi_wdata(spi_wdata),
    .spi_rdata(spi_rdata), .spi_ack(spi_ack),
    .slot(slot), .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din),
    .ram_data_oe(ram_data_oe), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  always #5 clk = ~clk;

  // ---------------- SRAM device model ----------------
  logic [DW-1:0] sram    [0:MEM_WORDS-1];
  logic [DW-1:0] exp_mem [0:MEM_WORDS-1];
  assign ram_din = ram_oe_n ? '0 : sram[ram_addr];
  always @(posedge clk) if (!ram_we_n && ram_data_oe) sram[ram_addr] <= ram_dout;

  // ---------------- check bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slot-level reference model ----------------
  // t counts clocks since reset release; slot instance n = t/S owns
  // (n mod 3). The instance running at reset release never accesses.
  typedef struct packed {
    logic          valid;
    logic          rd;
    logic          wr;
    logic [1:0]    own;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } desc_t;

  int            t;
  desc_t         cur;
  logic [DW-1:0] e_cpu_rd, e_vid_rd, e_spi_rd, e_dout;
  logic [AW-1:0] e_addr;
  logic          e_done, e_valid, e_ack;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t = 0; cur = '0;
      e_cpu_rd = '0; e_vid_rd = '0; e_spi_rd = '0; e_dout = '0; e_addr = '0;
      e_done = 1'b0; e_valid = 1'b0; e_ack = 1'b0;
    end else begin
      t = t + 1;
      e_done = 1'b0; e_valid = 1'b0; e_ack = 1'b0;
      if (t % S == 0) begin
        if (cur.valid) begin
          if (cur.own == 2'd0) e_done  = 1'b1;
          if (cur.own == 2'd1) e_valid = 1'b1;
          if (cur.own == 2'd2) e_ack   = 1'b1;
          if (cur.rd) begin
            if (cur.own == 2'd0) e_cpu_rd = exp_mem[cur.addr];
            if (cur.own == 2'd1) e_vid_rd = exp_mem[cur.addr];
            if (cur.own == 2'd2) e_spi_rd = exp_mem[cur.addr];
          end
          if (cur.wr) exp_mem[cur.addr] = cur.data;
        end
        cur = '0;
        cur.own = 2'((t / S) % 3);
        if (cur.own == 2'd0) begin
          cur.valid = 1'b1;
          cur.rd = cpu_ram_enable && !cpu_we;
          cur.wr = cpu_ram_enable && cpu_we && !cpu_is_readonly;
          cur.addr = cpu_addr; cur.data = cpu_wdata;
        end else if (cur.own == 2'd1) begin
          cur.valid = 1'b1; cur.rd = 1'b1; cur.addr = video_addr;
        end else begin
          cur.valid = spi_req; cur.rd = spi_req && !spi_we; cur.wr = spi_req && spi_we;
          cur.addr = spi_addr; cur.data = spi_wdata;
        end
        if (cur.rd || cur.wr) e_addr = cur.addr;
        if (cur.wr) e_dout = cur.data;
      end
    end
  end

  // Compare every DUT output against the model, away from the active edge.
  always @(negedge clk) begin
    int p;
    p = t % S;
    check("slot", 32'(slot), 32'((t / S) % 3));
    check("ram_oe_n", 32'(ram_oe_n), 32'(!cur.rd));
    check("ram_data_oe", 32'(ram_data_oe), 32'(cur.wr));
    check("ram_we_n", 32'(ram_we_n), 32'(!(cur.wr && p >= 1 && p <= S - 2)));
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    check("ram_dout", 32'(ram_dout), 32'(e_dout));
    check("cpu_done", 32'(cpu_done), 32'(e_done));
    check("video_valid", 32'(video_valid), 32'(e_valid));
    check("spi_ack", 32'(spi_ack), 32'(e_ack));
    check("cpu_rdata", 32'(cpu_rdata), 32'(e_cpu_rd));
    check("video_rdata", 32'(video_rdata), 32'(e_vid_rd));
    check("spi_rdata", 32'(spi_rdata), 32'(e_spi_rd));
  end

  // ---------------- event monitor ----------------
  int cyc = 0, n_ack = 0, n_cpu_we = 0, n_cpu_oe = 0;
  int vv_times[$];
  always @(negedge clk) begin
    cyc++;
    if (spi_ack) n_ack++;
    if (video_valid) vv_times.push_back(cyc);
    if (!ram_we_n && slot == 2'd0) n_cpu_we++;
    if (!ram_oe_n && slot == 2'd0) n_cpu_oe++;
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // which: 0 cpu_done, 1 video_valid, 2 spi_ack. lat = edges waited, -1 on timeout.
  task automatic wait_pulse(input int which, input int bound, output int lat);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clk); #1;
      if ((which == 0 && cpu_done) || (which == 1 && video_valid) || (which == 2 && spi_ack)) begin
        lat = i;
        return;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat, snap, snap2, n_req, mism;
    logic [DW-1:0] f000_orig;

    for (int i = 0; i < MEM_WORDS; i++) begin
      sram[i] = 8'(i) ^ 8'(i >> 8);
      exp_mem[i] = sram[i];
    end
    sram[17'h08000] = 8'h5A; exp_mem[17'h08000] = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      sram[17'h0E100 + k] = 8'hC0 + 8'(k);
      exp_mem[17'h0E100 + k] = 8'hC0 + 8'(k);
    end
    f000_orig = sram[17'h0F000];

    cpu_addr = 17'h08000; cpu_we = 1'b0; cpu_ram_enable = 1'b1;

    // Reset state.
    step(3);
    check("reset_oe_n", 32'(ram_oe_n), 32'd1);
    check("reset_we_n", 32'(ram_we_n), 32'd1);
    check("reset_data_oe", 32'(ram_data_oe), 32'd0);
    check("reset_addr", 32'(ram_addr), 32'd0);
    check("reset_slot", 32'(slot), 32'd0);
    reset_n = 1'b1;

    // Slot rotation: 4 clocks each.
    step(4);  check("rot_video", 32'(slot), 32'd1);
    step(4);  check("rot_spi", 32'(slot), 32'd2);
    step(4);  check("rot_cpu", 32'(slot), 32'd0);

    // CPU read $8000.
    check("cpu_rd_oe", 32'(ram_oe_n), 32'd0);
    check("cpu_rd_addr", 32'(ram_addr), 32'h08000);
    snap = n_cpu_oe;
    wait_pulse(0, 3 * S + 2, lat);
    check("cpu_rd_done_lat", 32'(lat), 32'd4);
    check("cpu_rd_data", 32'(cpu_rdata), 32'h5A);
    check("cpu_rd_oe_cycles", 32'(n_cpu_oe - snap), 32'd4);

    // CPU write to ROM: suppressed, but done still pulses.
    cpu_addr = 17'h0F000; cpu_we = 1'b1; cpu_wdata = 8'h11; cpu_is_readonly = 1'b1;
    snap = n_cpu_we;
    wait_pulse(0, 3 * S + 2, lat);
    check("rom_wr_done", 32'(lat > 0), 32'd1);
    check("rom_wr_we_cycles", 32'(n_cpu_we - snap), 32'd0);
    check("rom_wr_mem", 32'(sram[17'h0F000]), 32'(f000_orig));

    // CPU write to RAM $0100.
    cpu_addr = 17'h00100; cpu_is_readonly = 1'b0;
    snap = n_cpu_we;
    wait_pulse(0, 3 * S + 2, lat);
    check("ram_wr_done", 32'(lat > 0), 32'd1);
    check("ram_wr_we_cycles", 32'(n_cpu_we - snap), 32'd2);
    check("ram_wr_mem", 32'(sram[17'h00100]), 32'h11);
    cpu_ram_enable = 1'b0; cpu_we = 1'b0;

    // SPI write raised at phase 1 of an SPI slot: served next round.
    lat = -1;
    for (int i = 0; i < 3 * S + 1; i++) begin
      if ((t / S) % 3 == 2 && t % S == 1) begin lat = 0; break; end
      step(1);
    end
    check("spi_phase1_found", 32'(lat), 32'd0);
    snap = n_ack;
    spi_addr = 17'h0E000; spi_we = 1'b1; spi_wdata = 8'hA5; spi_req = 1'b1;
    wait_pulse(2, 4 * S + 1, lat);
    spi_req = 1'b0;
    check("spi_wr_latency", 32'(lat), 32'd15);
    check("spi_wr_mem", 32'(sram[17'h0E000]), 32'hA5);
    step(3 * S * 2);
    check("spi_wr_one_ack", 32'(n_ack - snap), 32'd1);

    // Video read $8000 every round while SPI reads a 4-word burst.
    video_addr = 17'h08000;
    vv_times.delete();
    snap = n_ack;
    for (int k = 0; k < 4; k++) begin
      spi_addr = 17'h0E100 + AW'(k); spi_we = 1'b0; spi_req = 1'b1;
      wait_pulse(2, 4 * S + 1, lat);
      check("burst_ack_seen", 32'(lat > 0), 32'd1);
      check("burst_rdata", 32'(spi_rdata), 32'hC0 + 32'(k));
    end
    spi_req = 1'b0;
    step(2);
    check("burst_acks", 32'(n_ack - snap), 32'd4);
    check("video_rdata_8000", 32'(video_rdata), 32'h5A);
    check("video_valid_count", 32'(vv_times.size() >= 4), 32'd1);
    for (int i = 1; i < vv_times.size(); i++)
      check("video_valid_period", 32'(vv_times[i] - vv_times[i-1]), 32'd12);

    // Reset during phase 2 of an SPI write.
    spi_addr = 17'h0E800; spi_we = 1'b1; spi_wdata = 8'h3C; spi_req = 1'b1;
    lat = -1;
    for (int i = 0; i < 6 * S; i++) begin
      if (slot == 2'd2 && t % S == 2 && ram_data_oe) begin lat = 0; break; end
      step(1);
    end
    check("rst_mid_found", 32'(lat), 32'd0);
    check("rst_mid_we_low", 32'(ram_we_n), 32'd0);
    snap = n_ack;
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_we_released", 32'(ram_we_n), 32'd1);
    check("rst_mid_drive_released", 32'(ram_data_oe), 32'd0);
    step(2);
    check("rst_mid_no_ack", 32'(n_ack - snap), 32'd0);
    reset_n = 1'b1;
    wait_pulse(2, 5 * S, lat);
    spi_req = 1'b0;
    check("rst_after_latency", 32'(lat), 32'd12);
    check("rst_after_mem", 32'(sram[17'h0E800]), 32'h3C);
    step(3 * S * 2);
    check("rst_after_one_ack", 32'(n_ack - snap), 32'd1);

    // Randomized traffic.
    snap2 = n_ack;
    n_req = 0;
    for (int i = 0; i < 600; i++) begin
      step(1);
      if ((t / S) % 3 == 1) begin
        cpu_addr = AW'($urandom_range(0, 17'h0DFFF));
        cpu_we = 1'($urandom); cpu_wdata = 8'($urandom);
        cpu_ram_enable = 1'($urandom); cpu_is_readonly = 1'($urandom);
      end
      if ((t / S) % 3 == 0) video_addr = AW'($urandom_range(0, 17'h0DFFF));
      if (spi_req && spi_ack) spi_req = 1'b0;
      else if (!spi_req && $urandom_range(0, 2) == 0) begin
        spi_addr = AW'($urandom_range(0, 17'h0DFFF));
        spi_we = 1'($urandom); spi_wdata = 8'($urandom);
        spi_req = 1'b1;
        n_req++;
      end
    end
    lat = -1;
    for (int i = 0; i < 5 * S; i++) begin
      if (!spi_req) begin lat = 0; break; end
      step(1);
      if (spi_ack) spi_req = 1'b0;
    end
    check("rand_drain", 32'(lat), 32'd0);
    step(2);
    check("rand_ack_count", 32'(n_ack - snap2), 32'(n_req));

    mism = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (sram[i] !== exp_mem[i]) mism++;
    check("mem_final", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
